// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register placed between two core stages.
// Carries a valid bit alongside PC and instruction, supports stall (hold),
// multi-cycle flush (squash for a programmable number of edges) and keeps
// a saturating count of the bubbles it has written.
module pipe_stage_reg #(
  parameter int                 INSTR_W  = 16,
  parameter int                 PC_W     = 16,
  parameter logic [INSTR_W-1:0] NOP_WORD = {INSTR_W{1'b0}},
  parameter int                 FLUSH_W  = 2,
  parameter int                 PERF_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [FLUSH_W-1:0] flush,
  input  logic               valid_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               perf_clr,
  output logic               valid_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               squashing,
  output logic [PERF_W-1:0]  bubble_count
);

  // What the stage does on the coming edge, in decreasing priority.
  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,  // new flush request: write a bubble, reload squash count
    ACT_SQUASH = 2'd1,  // squash in progress: write a bubble, count down
    ACT_HOLD   = 2'd2,  // stall with no squash: keep everything
    ACT_LOAD   = 2'd3   // normal transfer from upstream
  } action_e;

  // Stage state.
  logic               r_valid;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [FLUSH_W-1:0] r_squash_cnt;
  logic [PERF_W-1:0]  r_bubble_count;

  // Next-state values.
  action_e            w_action;
  logic               w_valid_nxt;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [INSTR_W-1:0] w_instr_nxt;
  logic [FLUSH_W-1:0] w_squash_cnt_nxt;
  logic               w_bubble;
  logic               w_count_full;
  logic [PERF_W-1:0]  w_bubble_count_nxt;

  // Classify the coming edge: flush beats squash beats stall beats load.
  always_comb begin
    w_action = ACT_LOAD;
    if (flush != '0) begin
      w_action = ACT_FLUSH;
    end else if (r_squash_cnt != '0) begin
      w_action = ACT_SQUASH;
    end else if (stall) begin
      w_action = ACT_HOLD;
    end
  end

  // Next payload, valid and squash count for the classified action.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_valid_nxt      = r_valid;
    w_pc_nxt         = r_pc;
    w_instr_nxt      = r_instr;
    w_squash_cnt_nxt = r_squash_cnt;
    w_bubble         = 1'b0;
    case (w_action)
      ACT_FLUSH: begin
        // A fresh flush reloads the count; it never adds to a running squash.
        w_valid_nxt      = 1'b0;
        w_pc_nxt         = pc_in;
        w_instr_nxt      = NOP_WORD;
        w_squash_cnt_nxt = flush - FLUSH_W'(1);
        w_bubble         = 1'b1;
      end
      ACT_SQUASH: begin
        // Squash cycles always elapse, even under stall. The PC keeps
        // following upstream so PC-relative logic sees the current fetch PC.
        w_valid_nxt      = 1'b0;
        w_pc_nxt         = pc_in;
        w_instr_nxt      = NOP_WORD;
        w_squash_cnt_nxt = r_squash_cnt - FLUSH_W'(1);
        w_bubble         = 1'b1;
      end
      ACT_HOLD: begin
        // Stall keeps everything as it is; holding is not a bubble.
        w_bubble = 1'b0;
      end
      ACT_LOAD: begin
        w_valid_nxt = valid_in;
        w_pc_nxt    = pc_in;
        w_instr_nxt = valid_in ? instr_in : NOP_WORD;
        w_bubble    = ~valid_in;
      end
      default: begin
        w_bubble = 1'b0;
      end
    endcase
  end

  // Bubble counter next value: clear wins, otherwise saturating increment.
  always_comb begin
    w_count_full       = (r_bubble_count == {PERF_W{1'b1}});
    w_bubble_count_nxt = r_bubble_count;
    if (perf_clr) begin
      w_bubble_count_nxt = '0;
    end else if (w_bubble && !w_count_full) begin
      w_bubble_count_nxt = r_bubble_count + PERF_W'(1);
    end
  end

  // Pipeline register: async reset to an invalid NOP with no squash pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_instr      <= NOP_WORD;
      r_squash_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      r_valid      <= w_valid_nxt;
      r_pc         <= w_pc_nxt;
      r_instr      <= w_instr_nxt;
      r_squash_cnt <= w_squash_cnt_nxt;
    end
  end

  // Bubble counter register, cleared by reset as well.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_count <= '0;
    end else begin
      r_bubble_count <= w_bubble_count_nxt;
    end
  end

  assign valid_out    = r_valid;
  assign pc_out       = r_pc;
  assign instr_out    = r_instr;
  assign squashing    = (r_squash_cnt != '0);
  assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg. Two instances share one stimulus stream:
// one with a wide bubble counter, one with a 2-bit counter to reach
// saturation. A driver pushes expected post-edge state into a queue; a
// monitor pops and compares after every rising edge.
module tb_pipe_stage_reg;

  localparam int                INSTR_W = 16;
  localparam int                PC_W    = 16;
  localparam int                FLUSH_W = 2;
  localparam int                PERF_A  = 16;
  localparam int                PERF_B  = 2;
  localparam logic [INSTR_W-1:0] NOP    = 16'h0013;

  logic               clk;
  logic               reset;
  logic               stall;
  logic [FLUSH_W-1:0] flush;
  logic               valid_in;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instr_in;
  logic               perf_clr;

  logic               a_valid, b_valid;
  logic [PC_W-1:0]    a_pc, b_pc;
  logic [INSTR_W-1:0] a_instr, b_instr;
  logic               a_sq, b_sq;
  logic [PERF_A-1:0]  a_bc;
  logic [PERF_B-1:0]  b_bc;

  pipe_stage_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_WORD(NOP),
                   .FLUSH_W(FLUSH_W), .PERF_W(PERF_A)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
    .perf_clr(perf_clr), .valid_out(a_valid), .pc_out(a_pc),
    .instr_out(a_instr), .squashing(a_sq), .bubble_count(a_bc));

  pipe_stage_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_WORD(NOP),
                   .FLUSH_W(FLUSH_W), .PERF_W(PERF_B)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
    .perf_clr(perf_clr), .valid_out(b_valid), .pc_out(b_pc),
    .instr_out(b_instr), .squashing(b_sq), .bubble_count(b_bc));

  typedef struct {
    logic               v;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               sq;
    logic [PERF_A-1:0]  bc_a;
    logic [PERF_B-1:0]  bc_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state, expressed as plain quantities.
  logic               m_valid;
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  int                 m_squash_left;   // further edges still to squash
  longint             m_bubbles;       // bubbles since last clear, unbounded

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint b, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (b > mx) ? mx : b;
  endfunction

  // Advance the model by one edge using the stage rules directly.
  task automatic model_step(input logic rst, input logic st, input logic [FLUSH_W-1:0] fl,
                            input logic v, input logic [PC_W-1:0] pc,
                            input logic [INSTR_W-1:0] instr, input logic clr);
    bit   bubble;
    exp_t e;
    bubble = 0;
    if (rst) begin
      m_valid = 0; m_pc = '0; m_instr = NOP; m_squash_left = 0; m_bubbles = 0;
    end else begin
      if (fl != 0) begin
        m_valid = 0; m_pc = pc; m_instr = NOP; m_squash_left = int'(fl) - 1; bubble = 1;
      end else if (m_squash_left > 0) begin
        m_valid = 0; m_pc = pc; m_instr = NOP; m_squash_left--; bubble = 1;
      end else if (!st) begin
        m_valid = v; m_pc = pc; m_instr = v ? instr : NOP; bubble = !v;
      end
      if (clr) m_bubbles = 0;
      else if (bubble) m_bubbles++;
    end
    e.v     = m_valid;
    e.pc    = m_pc;
    e.instr = m_instr;
    e.sq    = (m_squash_left != 0);
    e.bc_a  = PERF_A'(sat(m_bubbles, PERF_A));
    e.bc_b  = PERF_B'(sat(m_bubbles, PERF_B));
    exp_q.push_back(e);
  endtask

  // Present one cycle of inputs at the falling edge; a reset request is
  // asserted mid-cycle and its immediate effect is checked before the edge.
  task automatic drive(input logic rst, input logic st, input logic [FLUSH_W-1:0] fl,
                       input logic v, input logic [PC_W-1:0] pc,
                       input logic [INSTR_W-1:0] instr, input logic clr);
    @(negedge clk);
    stall = st; flush = fl; valid_in = v; pc_in = pc; instr_in = instr; perf_clr = clr;
    reset = rst;
    model_step(rst, st, fl, v, pc, instr, clr);
    if (rst) begin
      #1;
      check("rst_valid", {63'd0, a_valid}, 64'd0);
      check("rst_pc", {48'd0, a_pc}, 64'd0);
      check("rst_instr", {48'd0, a_instr}, {48'd0, NOP});
      check("rst_squashing", {63'd0, a_sq}, 64'd0);
      check("rst_bc_a", {48'd0, a_bc}, 64'd0);
      check("rst_bc_b", {62'd0, b_bc}, 64'd0);
      check("rst_b_instr", {48'd0, b_instr}, {48'd0, NOP});
    end
  endtask

  // Monitor: one expected entry per edge driven, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid_out", {63'd0, a_valid}, {63'd0, e.v});
        check("pc_out", {48'd0, a_pc}, {48'd0, e.pc});
        check("instr_out", {48'd0, a_instr}, {48'd0, e.instr});
        check("squashing", {63'd0, a_sq}, {63'd0, e.sq});
        check("bubble_count_a", {48'd0, a_bc}, {48'd0, e.bc_a});
        check("bubble_count_b", {62'd0, b_bc}, {62'd0, e.bc_b});
        check("b_payload", {31'd0, b_valid, b_sq, b_pc, b_instr},
              {31'd0, e.v, e.sq, e.pc, e.instr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 0; flush = '0; valid_in = 0; pc_in = '0; instr_in = '0; perf_clr = 0;
    m_valid = 0; m_pc = '0; m_instr = NOP; m_squash_left = 0; m_bubbles = 0;

    // Reset then load
    drive(1, 0, 0, 1, 16'h0010, 16'hA5A5, 0);
    drive(0, 0, 0, 1, 16'h0010, 16'hA5A5, 0);
    // Stall hold for three cycles, then release
    repeat (3) drive(0, 1, 0, 1, 16'h0012, 16'h1234, 0);
    drive(0, 0, 0, 1, 16'h0012, 16'h1234, 0);
    // Multi-cycle flush issued under stall
    drive(0, 1, 3, 1, 16'h0020, 16'h5555, 0);
    drive(0, 0, 0, 1, 16'h0021, 16'h7777, 0);
    drive(0, 0, 0, 1, 16'h0022, 16'h7777, 0);
    drive(0, 0, 0, 1, 16'h0023, 16'h7777, 0);
    // Flush reload: 3 then 2 gives three squashed edges in total
    drive(0, 0, 3, 1, 16'h0030, 16'h1111, 0);
    drive(0, 0, 2, 1, 16'h0031, 16'h2222, 0);
    drive(0, 1, 0, 1, 16'h0032, 16'h3333, 0);
    drive(0, 0, 0, 1, 16'h0033, 16'h4444, 0);
    // Invalid input to saturate the narrow counter, then clear
    repeat (5) drive(0, 0, 0, 0, 16'h0034, 16'hFFFF, 0);
    drive(0, 0, 0, 0, 16'h0035, 16'hFFFF, 1);
    drive(0, 0, 1, 1, 16'h0036, 16'hFFFF, 0);
    drive(0, 0, 0, 1, 16'h0037, 16'h6666, 0);
    // Reset in the middle of a squash
    drive(0, 0, 3, 1, 16'h0040, 16'h8888, 0);
    drive(1, 0, 0, 1, 16'h0041, 16'h9999, 0);
    drive(0, 0, 0, 1, 16'h0042, 16'hBEEF, 0);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      logic               r_rst, r_st, r_v, r_clr;
      logic [FLUSH_W-1:0] r_fl;
      r_rst = ($urandom_range(0, 63) == 0);
      r_st  = ($urandom_range(0, 2) == 0);
      r_fl  = ($urandom_range(0, 7) == 0) ? FLUSH_W'($urandom_range(1, 3)) : '0;
      r_v   = ($urandom_range(0, 3) != 0);
      r_clr = ($urandom_range(0, 31) == 0);
      drive(r_rst, r_st, r_fl, r_v, PC_W'($urandom), INSTR_W'($urandom), r_clr);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
